// File: rtl/jk_drive_controller.sv
// jk_drive_controller: drives J/K of an external JK flop (clocked by clk)
// toward a requested Q value, then checks the fed-back Q.
// Optional feature: define JK_DRIVE_RETRY_EN to re-drive after a failed
// check, up to MAX_RETRY extra attempts, before reporting an error.
module jk_drive_controller #(
    parameter bit PREFER_TOGGLE = 1'b0,
    parameter int MAX_RETRY     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_target,
    output logic req_ready,
    input  logic q_fb,
    output logic j,
    output logic k,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t state;
    logic   tgt;

    // A negative retry limit is meaningless in every build.
    if (MAX_RETRY < 0) begin : g_bad_max_retry
        $error("MAX_RETRY must be non-negative");
    end

    // J/K needed to move Q from q to t on the next clk edge.
    function automatic logic [1:0] excite(input logic q, input logic t);
        if (q == t)
            return 2'b00;
        else if (PREFER_TOGGLE)
            return 2'b11;
        else
            return t ? 2'b10 : 2'b01;
    endfunction

    // Accept only while idle and never during reset.
    assign req_ready = (state == IDLE) && !rst;

`ifdef JK_DRIVE_RETRY_EN
    localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [CW-1:0] retry_cnt;
`endif

    // Control FSM: J/K live for exactly one DRIVE cycle, Q is judged in CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tgt   <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef JK_DRIVE_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    j <= 1'b0;
                    k <= 1'b0;
                    if (req_valid) begin
                        tgt    <= req_target;
                        {j, k} <= excite(q_fb, req_target);
                        state  <= DRIVE;
`ifdef JK_DRIVE_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                DRIVE: begin
                    // The external flop samples J/K on this edge.
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (q_fb == tgt) begin
                        done  <= 1'b1;
                        state <= IDLE;
`ifdef JK_DRIVE_RETRY_EN
                    end else if (retry_cnt < CW'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + CW'(1);
                        {j, k}    <= excite(q_fb, tgt);
                        state     <= DRIVE;
`endif
                    end else begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_drive_controller.sv
// Bench for jk_drive_controller: two instances (PREFER_TOGGLE 0 and 1) share
// stimulus, each with its own JK flop model and a timeline reference model.
module tb_jk_drive_controller;

`ifdef JK_DRIVE_RETRY_EN
    localparam int MAXR = 2;
`else
    localparam int MAXR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, req_valid, req_target;
    logic [1:0] qm;                 // external flop Q per instance
    logic       ld, stuck;
    logic [1:0] ldv;
    logic [1:0] rdy, jj, kk, dn, er;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    jk_drive_controller #(.PREFER_TOGGLE(1'b0), .MAX_RETRY(2)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_target(req_target),
        .req_ready(rdy[0]), .q_fb(qm[0]), .j(jj[0]), .k(kk[0]),
        .done(dn[0]), .err(er[0]));

    jk_drive_controller #(.PREFER_TOGGLE(1'b1), .MAX_RETRY(2)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_target(req_target),
        .req_ready(rdy[1]), .q_fb(qm[1]), .j(jj[1]), .k(kk[1]),
        .done(dn[1]), .err(er[1]));

    // External JK flops; ld preloads Q, stuck pins Q at 0.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ld)         qm[d] <= ldv[d];
            else if (stuck) qm[d] <= 1'b0;
            else case ({jj[d], kk[d]})
                2'b01:   qm[d] <= 1'b0;
                2'b10:   qm[d] <= 1'b1;
                2'b11:   qm[d] <= ~qm[d];
                default: qm[d] <= qm[d];
            endcase
        end
    end

    // Reference model: per operation, age counts cycles since acceptance.
    // Odd ages are drive cycles, even ages are judgement cycles.
    int m_age[2]   = '{-1, -1};
    int m_tries[2] = '{0, 0};
    bit m_tgt[2];
    bit ej[2], ek[2], ed[2], ee[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit pt, chg;
            pt = (d == 1);
            ej[d] = 0; ek[d] = 0; ed[d] = 0; ee[d] = 0;
            if (rst) begin
                m_age[d] = -1;
                m_tries[d] = 0;
            end else if (m_age[d] < 0) begin
                if (req_valid) begin
                    m_tgt[d] = req_target;
                    m_tries[d] = 0;
                    m_age[d] = 1;
                    chg = (qm[d] != req_target);
                    ej[d] = chg && (req_target || pt);
                    ek[d] = chg && (!req_target || pt);
                end
            end else if (m_age[d] % 2 == 1) begin
                m_age[d] = m_age[d] + 1;
            end else if (qm[d] == m_tgt[d]) begin
                ed[d] = 1;
                m_age[d] = -1;
            end else if (m_tries[d] < MAXR) begin
                m_tries[d] = m_tries[d] + 1;
                m_age[d] = m_age[d] + 1;
                ej[d] = m_tgt[d] || pt;
                ek[d] = !m_tgt[d] || pt;
            end else begin
                ed[d] = 1;
                ee[d] = 1;
                m_age[d] = -1;
            end
        end
    end

    task automatic cmp(input string name, input int d, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic cmpi(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                cmp("ready", d, rdy[d], (m_age[d] < 0) && !rst);
                cmp("j", d, jj[d], ej[d]);
                cmp("k", d, kk[d], ek[d]);
                cmp("done", d, dn[d], ed[d]);
                cmp("err", d, er[d], ee[d]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setq(input logic v0, input logic v1);
        @(negedge clk);
        #1;
        ld = 1'b1;
        ldv = {v1, v0};
        step();
        ld = 1'b0;
    endtask

    // Offer a request and return one time unit after the accepting edge.
    task automatic go(input logic t);
        @(negedge clk);
        #1;
        req_valid = 1'b1;
        req_target = t;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int lat, pulses;
        rst = 1'b1; req_valid = 1'b0; req_target = 1'b0;
        ld = 1'b0; ldv = 2'b00; stuck = 1'b0;
        step();
        chk_en = 1;
        step();
        for (int d = 0; d < 2; d++) begin
            cmp("rst_j", d, jj[d], 1'b0);
            cmp("rst_done", d, dn[d], 1'b0);
            cmp("rst_ready", d, rdy[d], 1'b0);
        end
        rst = 1'b0;

        // 0 -> 1: dut0 sets (10), dut1 toggles (11).
        setq(1'b0, 1'b0);
        go(1'b1);
        cmp("s1_j", 0, jj[0], 1'b1); cmp("s1_k", 0, kk[0], 1'b0);
        cmp("s1_j", 1, jj[1], 1'b1); cmp("s1_k", 1, kk[1], 1'b1);
        step();
        cmp("s1_j_off", 0, jj[0], 1'b0);
        step();
        cmp("s1_done", 0, dn[0], 1'b1); cmp("s1_err", 0, er[0], 1'b0);
        cmp("s1_done", 1, dn[1], 1'b1);
        cmp("s1_q", 0, qm[0], 1'b1);

        // 1 -> 0: dut0 resets (01), dut1 toggles (11).
        go(1'b0);
        cmp("s2_j", 1, jj[1], 1'b1); cmp("s2_k", 1, kk[1], 1'b1);
        cmp("s2_j", 0, jj[0], 1'b0); cmp("s2_k", 0, kk[0], 1'b1);
        step(); step();
        cmp("s2_done", 1, dn[1], 1'b1); cmp("s2_err", 1, er[1], 1'b0);
        cmp("s2_q", 1, qm[1], 1'b0);

        // Hold 1 -> 1: no excitation, same latency.
        setq(1'b1, 1'b1);
        go(1'b1);
        cmp("s3_j", 0, jj[0], 1'b0); cmp("s3_k", 0, kk[0], 1'b0);
        cmp("s3_j", 1, jj[1], 1'b0);
        step(); step();
        cmp("s3_done", 0, dn[0], 1'b1); cmp("s3_err", 0, er[0], 1'b0);

        // Flop stuck at 0, target 1.
        setq(1'b0, 1'b0);
        stuck = 1'b1;
        go(1'b1);
        lat = -1; pulses = 0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            if (jj[0] && !kk[0]) pulses++;
            if (dn[0]) begin
                lat = c;
                cmp("s4_err", 0, er[0], 1'b1);
            end
            if (lat < 0) step();
        end
        cmpi("s4_latency", lat, 3 + 2 * MAXR);
        cmpi("s4_pulses", pulses, 1 + MAXR);
        stuck = 1'b0;
        step();

        // Reset in the middle of DRIVE abandons the operation.
        setq(1'b0, 1'b0);
        go(1'b1);
        rst = 1'b1;
        step();
        cmp("s5_j", 0, jj[0], 1'b0); cmp("s5_k", 1, kk[1], 1'b0);
        cmp("s5_done", 0, dn[0], 1'b0);
        rst = 1'b0;
        #1;
        cmp("s5_ready", 0, rdy[0], 1'b1);
        step(); step();
        cmp("s5_nodone", 0, dn[0], 1'b0);

        // Back-to-back: valid held high, second request taken on the done cycle.
        setq(1'b0, 1'b0);
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_target = 1'b1;
        step();
        req_target = 1'b0;          // ignored while busy
        step(); step();
        cmp("b2b_done1", 0, dn[0], 1'b1); cmp("b2b_ready", 0, rdy[0], 1'b1);
        step();
        req_valid = 1'b0;
        cmp("b2b_j", 0, jj[0], 1'b0); cmp("b2b_k", 0, kk[0], 1'b1);
        cmp("b2b_j", 1, jj[1], 1'b1);
        step(); step();
        cmp("b2b_done2", 0, dn[0], 1'b1); cmp("b2b_err2", 0, er[0], 1'b0);
        cmp("b2b_q", 0, qm[0], 1'b0);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
